alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//   Shares one 64-bit combinational/pipelined ALU (ADD/SUB/AND/OR/XOR/SLT) between two requesters.
//   Round-robin arbitration, operand capture, ALU_LAT-cycle execute wait, then a held response
//   with requester ID. Sits between the issue ports and the shared ALU datapath; one op in flight.
// PARAMETERS
//   W        64  operand/result width
//   ALU_LAT  1   cycles from alu_op/alu_a/alu_b stable to alu_result valid (>=1)
// PORTS
//   clk          in   1   clock, rising edge
//   rst_n        in   1   asynchronous active-low reset
//   req0_valid   in   1   requester 0 has an op
//   req0_ready   out  1   requester 0 op accepted this cycle (when valid&ready)
//   req0_op      in   3   opcode
//   req0_a       in   W   operand A
//   req0_b       in   W   operand B
//   req1_*       --   --  identical set for requester 1
//   alu_op       out  3   opcode to shared ALU
//   alu_a        out  W   operand A to ALU
//   alu_b        out  W   operand B to ALU
//   alu_result   in   W   ALU result (SLT returns bit0, upper bits zero)
//   rsp_valid    out  1   response available
//   rsp_ready    in   1   consumer accepts response
//   rsp_id       out  1   requester that issued the op
//   rsp_result   out  W   captured result
//   rsp_err      out  1   illegal opcode flag
// BEHAVIOUR
//   Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT (signed A<B), 110/111 illegal.
//   Reset (async, rst_n=0): state=IDLE, rr pointer -> req0 priority, alu_op/a/b=0, rsp_valid=0,
//     rsp_id=0, rsp_result=0, rsp_err=0, count=0. Both req*_ready=0 while in reset.
//   FSM IDLE -> EXEC -> RESP -> IDLE:
//   - IDLE: grant = pointer-priority winner among valid requesters; only granted reqN_ready=1
//     (combinational from valids and state); ready=0 in every other state. On accept: latch
//     op/a/b/id into alu_op/alu_a/alu_b/id reg; legal op -> EXEC; illegal -> RESP directly with
//     rsp_err=1, rsp_result=0 (ALU not driven, alu_* keep previous values). Pointer moves so the
//     accepted requester gets lowest priority next. No valid -> stay IDLE, pointer unchanged.
//   - EXEC: alu_* held stable; counter runs ALU_LAT cycles; on last EXEC cycle capture alu_result
//     into rsp_result, rsp_err=0 -> RESP.
//   - RESP: rsp_valid=1; rsp_id/result/err stable until rsp_valid&rsp_ready; then IDLE.
//   Timing: accept at edge 0 -> EXEC cycles 1..ALU_LAT -> rsp_valid high from cycle ALU_LAT+1.
//     With rsp_ready held high, back-to-back ops issue every ALU_LAT+2 cycles.
//   Both valid same cycle: pointer decides; after reset req0 wins. A requester holding valid
//     while not granted must keep op/a/b stable (no drop); controller never accepts two at once.
//   Single active requester is accepted every slot regardless of pointer (no idle bubbles).
//   Reset mid-EXEC/RESP: op discarded, no response produced, outputs to reset values.
//   rsp_result width rule: stored as given by ALU; controller performs no extension or masking.
// TESTING
//   req0 SLT A=FFFF_FFFF_FFFF_FFF6 B=FFFF_FFFF_FFFF_FFFB, ALU_LAT=1 -> rsp_valid at cycle 2, rsp_id=0, rsp_result=1.
//   req0 ADD 5+10 and req1 SUB 10-5 both valid after reset -> responses id0=0xF then id1=0x5, in that order.
//   Both held valid with 4 ops each -> grants alternate 0,1,0,1,...; no requester granted twice in a row.
//   req1 SLT A=0 B=0, rsp_ready low 5 cycles -> rsp_valid/id/result(=0) stable, req*_ready=0 throughout.
//   req0 op=3'b111 -> rsp_valid cycle 1, rsp_err=1, rsp_result=0; next legal op returns rsp_err=0.
//   rst_n pulsed low during EXEC of req0 ADD -> no rsp_valid after release; all outputs at reset values.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - round-robin issue controller sharing one ALU between two requesters
// One op in flight: IDLE accepts, EXEC waits ALU_LAT cycles, RESP holds the result until taken.
module alu_issue_ctrl #(
  parameter int W       = 64,
  parameter int ALU_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [2:0]   req0_op,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [2:0]   req1_op,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic [2:0]   alu_op,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic [W-1:0] alu_result,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_result,
  output logic         rsp_err
);

  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state, state_nxt;
  logic           rr_ptr;
  logic [CW-1:0]  count;
  logic           grant0, grant1;
  logic           accept, acc_id, op_legal, last_exec;
  logic [2:0]     acc_op;
  logic [W-1:0]   acc_a, acc_b;

  // rr_ptr=0 gives req0 priority; a lone valid requester always wins.
  always_comb begin
    grant0     = req0_valid & (~rr_ptr | ~req1_valid);
    grant1     = req1_valid & (rr_ptr | ~req0_valid);
    req0_ready = grant0 & rst_n & (state == IDLE);
    req1_ready = grant1 & rst_n & (state == IDLE);
    accept     = req0_ready | req1_ready;
    acc_id     = req1_ready;
    acc_op     = acc_id ? req1_op : req0_op;
    acc_a      = acc_id ? req1_a  : req0_a;
    acc_b      = acc_id ? req1_b  : req0_b;
    op_legal   = (acc_op <= 3'b101);
    last_exec  = (count == CW'(ALU_LAT - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = op_legal ? EXEC : RESP;
      EXEC:    if (last_exec) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign rsp_valid = (state == RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= 1'b0;
      count      <= '0;
      alu_op     <= 3'b000;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
    end else begin
      if (accept) begin
        rr_ptr <= ~acc_id;
        rsp_id <= acc_id;
        count  <= '0;
        if (op_legal) begin
          alu_op <= acc_op;
          alu_a  <= acc_a;
          alu_b  <= acc_b;
        end else begin
          // Illegal ops skip the ALU; alu_* keep whatever was last issued.
          rsp_err    <= 1'b1;
          rsp_result <= '0;
        end
      end
      if (state == EXEC) begin
        if (last_exec) begin
          rsp_result <= alu_result;
          rsp_err    <= 1'b0;
          count      <= '0;
        end else begin
          count <= count + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed table-driven bench for alu_issue_ctrl
// Includes a reference model of the shared ALU feeding alu_result.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0]  req0_op, req1_op, alu_op;
  logic [63:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_result;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [63:0] rsp_result;

  int errors = 0;
  int checks = 0;

  alu_issue_ctrl #(.W(64), .ALU_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_alu(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return {63'd0, ($signed(a) < $signed(b))};
      default: return 64'd0;
    endcase
  endfunction

  assign alu_result = ref_alu(alu_op, alu_a, alu_b);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic id, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    bit got;
    got = 0;
    if (id) begin req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = id ? req1_ready : req0_ready;
    end
    if (!got) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    req0_valid = 0;
    req1_valid = 0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic handshake();
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
  endtask

  logic [2:0]  ops0[8], ops1[8];
  logic [63:0] a0[8], b0[8], a1[8], b1[8];

  task automatic run_both(input int n0, input int n1, input logic first);
    int k0, k1, nr, e0, e1;
    logic g0, g1, both, t, pick;
    logic gq[$];
    logic rid[$];
    logic [63:0] rres[$];
    logic egr[$];
    logic [63:0] eres[$];
    k0 = 0; k1 = 0; nr = 0; both = 0;
    rsp_ready = 1;
    if (n0 > 0) begin req0_valid = 1; req0_op = ops0[0]; req0_a = a0[0]; req0_b = b0[0]; end
    if (n1 > 0) begin req1_valid = 1; req1_op = ops1[0]; req1_a = a1[0]; req1_b = b1[0]; end
    for (int cyc = 0; cyc < 200 && nr < n0 + n1; cyc++) begin
      @(negedge clk);
      g0 = req0_ready; g1 = req1_ready;
      if (g0 && g1) both = 1;
      if (g0) gq.push_back(1'b0);
      if (g1) gq.push_back(1'b1);
      if (rsp_valid) begin
        rid.push_back(rsp_id);
        rres.push_back(rsp_result);
        nr++;
      end
      @(posedge clk); #1;
      if (g0) begin
        k0++;
        if (k0 < n0) begin req0_op = ops0[k0]; req0_a = a0[k0]; req0_b = b0[k0]; end
        else req0_valid = 0;
      end
      if (g1) begin
        k1++;
        if (k1 < n1) begin req1_op = ops1[k1]; req1_a = a1[k1]; req1_b = b1[k1]; end
        else req1_valid = 0;
      end
    end
    rsp_ready = 0;
    req0_valid = 0;
    req1_valid = 0;
    e0 = 0; e1 = 0; t = first;
    for (int i = 0; i < n0 + n1; i++) begin
      pick = (e0 < n0 && (t == 1'b0 || e1 >= n1)) ? 1'b0 : 1'b1;
      egr.push_back(pick);
      if (pick) begin eres.push_back(ref_alu(ops1[e1], a1[e1], b1[e1])); e1++; end
      else      begin eres.push_back(ref_alu(ops0[e0], a0[e0], b0[e0])); e0++; end
      t = ~pick;
    end
    chk("both_ready", {63'd0, both}, 64'd0);
    chk("rsp_count", nr, n0 + n1);
    for (int i = 0; i < n0 + n1; i++) begin
      chk($sformatf("grant[%0d]", i), (i < gq.size()) ? {63'd0, gq[i]} : 64'hX, {63'd0, egr[i]});
      chk($sformatf("rsp_id[%0d]", i), (i < rid.size()) ? {63'd0, rid[i]} : 64'hX, {63'd0, egr[i]});
      chk($sformatf("rsp_result[%0d]", i), (i < rres.size()) ? rres[i] : 64'hX, eres[i]);
    end
  endtask

  typedef struct {
    logic        id;
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int lat;
    logic [2:0]  prev_op;
    logic [63:0] prev_a;

    vecs[0]  = '{1'b0, 3'd5, 64'hFFFF_FFFF_FFFF_FFF6, 64'hFFFF_FFFF_FFFF_FFFB, 64'd1, 1'b0, 2};
    vecs[1]  = '{1'b1, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0, 2};
    vecs[2]  = '{1'b0, 3'd1, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 2};
    vecs[3]  = '{1'b1, 3'd2, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 64'hF000_F000_F000_F000, 1'b0, 2};
    vecs[4]  = '{1'b0, 3'd3, 64'h0F0F, 64'hF000, 64'hFF0F, 1'b0, 2};
    vecs[5]  = '{1'b1, 3'd4, 64'hAAAA_AAAA_AAAA_AAAA, 64'hFFFF_FFFF_FFFF_FFFF, 64'h5555_5555_5555_5555, 1'b0, 2};
    vecs[6]  = '{1'b0, 3'd5, 64'd5, 64'hFFFF_FFFF_FFFF_FFFD, 64'd0, 1'b0, 2};
    vecs[7]  = '{1'b1, 3'd5, 64'd0, 64'd0, 64'd0, 1'b0, 2};
    vecs[8]  = '{1'b0, 3'd6, 64'd7, 64'd9, 64'd0, 1'b1, 1};
    vecs[9]  = '{1'b1, 3'd7, 64'd3, 64'd4, 64'd0, 1'b1, 1};
    vecs[10] = '{1'b0, 3'd0, 64'd5, 64'd10, 64'hF, 1'b0, 2};

    rst_n = 0; rsp_ready = 0;
    req0_valid = 1; req0_op = 3'd0; req0_a = 64'd1; req0_b = 64'd2;
    req1_valid = 1; req1_op = 3'd1; req1_a = 64'd3; req1_b = 64'd4;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_req0_ready", {63'd0, req0_ready}, 64'd0);
    chk("rst_req1_ready", {63'd0, req1_ready}, 64'd0);
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_rsp_id", {63'd0, rsp_id}, 64'd0);
    chk("rst_rsp_result", rsp_result, 64'd0);
    chk("rst_rsp_err", {63'd0, rsp_err}, 64'd0);
    chk("rst_alu_op", {61'd0, alu_op}, 64'd0);
    chk("rst_alu_a", alu_a, 64'd0);
    chk("rst_alu_b", alu_b, 64'd0);
    req0_valid = 0; req1_valid = 0;
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    ops0[0] = 3'd0; a0[0] = 64'd5;  b0[0] = 64'd10;
    ops1[0] = 3'd1; a1[0] = 64'd10; b1[0] = 64'd5;
    run_both(1, 1, 1'b0);

    for (int i = 0; i < 4; i++) begin
      ops0[i] = 3'(i);     a0[i] = 64'h100 + 64'(i); b0[i] = 64'h0F;
      ops1[i] = 3'(i + 2); a1[i] = 64'(i);           b1[i] = 64'd2;
    end
    run_both(4, 4, 1'b0);

    prev_op = 3'd0; prev_a = 64'd0;
    foreach (vecs[i]) begin
      issue(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b);
      wait_rsp(lat);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_rsp_id", i), {63'd0, rsp_id}, {63'd0, vecs[i].id});
      chk($sformatf("v%0d_rsp_result", i), rsp_result, vecs[i].res);
      chk($sformatf("v%0d_rsp_err", i), {63'd0, rsp_err}, {63'd0, vecs[i].err});
      if (vecs[i].err) begin
        chk($sformatf("v%0d_alu_op_hold", i), {61'd0, alu_op}, {61'd0, prev_op});
        chk($sformatf("v%0d_alu_a_hold", i), alu_a, prev_a);
      end else begin
        prev_op = vecs[i].op;
        prev_a  = vecs[i].a;
      end
      handshake();
    end

    issue(1'b1, 3'd5, 64'd0, 64'd0);
    wait_rsp(lat);
    req0_valid = 1; req0_op = 3'd0; req0_a = 64'd1; req0_b = 64'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_rsp_valid", {63'd0, rsp_valid}, 64'd1);
      chk("hold_rsp_id", {63'd0, rsp_id}, 64'd1);
      chk("hold_rsp_result", rsp_result, 64'd0);
      chk("hold_req0_ready", {63'd0, req0_ready}, 64'd0);
      chk("hold_req1_ready", {63'd0, req1_ready}, 64'd0);
    end
    req0_valid = 0;
    handshake();

    issue(1'b0, 3'd0, 64'd1, 64'd2);
    rst_n = 0;
    #1;
    chk("mid_rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("mid_rst_alu_op", {61'd0, alu_op}, 64'd0);
    chk("mid_rst_alu_a", alu_a, 64'd0);
    chk("mid_rst_alu_b", alu_b, 64'd0);
    chk("mid_rst_rsp_id", {63'd0, rsp_id}, 64'd0);
    chk("mid_rst_rsp_result", rsp_result, 64'd0);
    chk("mid_rst_rsp_err", {63'd0, rsp_err}, 64'd0);
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
